// File: rtl/i_cache_sa.sv
// Set-associative instruction cache: per-set tree-PLRU replacement, line fills over a
// valid/ready memory port, set-by-set flush and wrapping hit/miss counters.
module i_cache_sa #(
    parameter int SETS       = 4,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic [31:0]              core_req_addr,
    output logic                     core_rsp_valid,
    output logic [31:0]              core_rsp_instr,
    output logic [31:0]              core_rsp_addr,
    input  logic                     flush,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rsp_data,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
    localparam int WAY_W = $clog2(WAYS);
    localparam int WRD_W = OFF_W - 2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] MISS_REQ  = 3'd2;
    localparam logic [2:0] MISS_WAIT = 3'd3;
    localparam logic [2:0] RESPOND   = 3'd4;
    localparam logic [2:0] FLUSH     = 3'd5;

    logic [2:0]                   state_q, state_d;
    logic [31:0]                  addr_q, addr_d;
    logic                         pend_q, pend_d;
    logic [SET_W-1:0]             fset_q, fset_d;
    logic [WAY_W-1:0]             way_q, way_d;
    logic [31:0]                  hit_cnt_q, miss_cnt_q;

    logic [WAYS-1:0]              valid_q [SETS];
    logic [WAYS-2:0]              plru_q  [SETS];
    logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
    logic [32*LINE_WORDS-1:0]     data_q  [SETS][WAYS];

    logic [SET_W-1:0]             set_idx;
    logic [TAG_W-1:0]             tag;
    logic [WRD_W-1:0]             word_sel;
    logic                         hit, found_free;
    logic [WAY_W-1:0]             hit_way, victim, rd_way;
    logic                         lookup_hit, lookup_miss, fill;

    // Each node bit is set to point away from the accessed way's half.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                  input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] t;
        int node;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int n = 0; n < WAYS - 1; n++)
                if (n == node) t[n] = ~way[WAY_W-1-lvl];
            node = 2 * node + 1 + int'(way[WAY_W-1-lvl]);
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] tree);
        logic b;
        int   node;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++)
                if (n == node) b = tree[n];
            node = 2 * node + 1 + int'(b);
        end
        return WAY_W'(node - (WAYS - 1));
    endfunction

    assign set_idx  = SET_W'((addr_q >> OFF_W) & 32'(SETS - 1));
    assign tag      = addr_q[31:OFF_W+IDX_W];
    assign word_sel = addr_q[OFF_W-1:2];

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_free = 1'b0;
        victim     = plru_victim(plru_q[set_idx]);
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_free && !valid_q[set_idx][w]) begin
                found_free = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    assign lookup_hit  = (state_q == LOOKUP) && hit;
    assign lookup_miss = (state_q == LOOKUP) && !hit;
    assign fill        = (state_q == MISS_WAIT) && mem_rsp_valid;
    assign rd_way      = (state_q == RESPOND) ? way_q : hit_way;

    assign core_req_ready = !rst && !flush && ((state_q == IDLE) || lookup_hit);
    assign core_rsp_valid = lookup_hit || (state_q == RESPOND);
    assign core_rsp_instr = core_rsp_valid ? data_q[set_idx][rd_way][32*word_sel +: 32] : '0;
    assign core_rsp_addr  = core_rsp_valid ? addr_q : '0;
    assign mem_req_valid  = (state_q == MISS_REQ);
    assign mem_req_addr   = mem_req_valid ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        fset_d  = fset_q;
        way_d   = way_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    fset_d  = '0;
                end else if (core_req_valid) begin
                    state_d = LOOKUP;
                    addr_d  = core_req_addr;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (flush) begin
                        state_d = FLUSH;
                        fset_d  = '0;
                    end else if (core_req_valid) begin
                        addr_d = core_req_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MISS_REQ;
                    pend_d  = flush;
                end
            end
            MISS_REQ: begin
                pend_d = pend_q | flush;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                pend_d = pend_q | flush;
                if (mem_rsp_valid) begin
                    state_d = RESPOND;
                    way_d   = victim;
                end
            end
            RESPOND: begin
                if (pend_q || flush) begin
                    state_d = FLUSH;
                    fset_d  = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                fset_d = fset_q + 1'b1;
                if (fset_q == SET_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            fset_q     <= '0;
            way_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            fset_q  <= fset_d;
            way_q   <= way_d;
            if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[fset_q] <= '0;
            plru_q[fset_q]  <= '0;
        end else if (lookup_hit) begin
            plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
        end else if (fill) begin
            valid_q[set_idx][victim] <= 1'b1;
            plru_q[set_idx]          <= plru_touch(plru_q[set_idx], victim);
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[set_idx][victim]  <= tag;
            data_q[set_idx][victim] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_i_cache_sa.sv
// Self-checking bench for i_cache_sa: directed scenarios followed by random fetches,
// compared against a line-address/PLRU-tree reference model and a synthetic memory.
module tb_i_cache_sa;
    localparam int SETS = 4;
    localparam int WAYS = 4;
    localparam int LVLS = 2;

    logic         clk;
    logic         rst;
    logic         core_req_valid;
    logic         core_req_ready;
    logic [31:0]  core_req_addr;
    logic         core_rsp_valid;
    logic [31:0]  core_rsp_instr;
    logic [31:0]  core_rsp_addr;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks;
    int failures;

    bit          m_valid [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    bit          m_node  [SETS][WAYS-1];
    int          m_hits;
    int          m_misses;

    i_cache_sa dut (
        .clk            (clk),
        .rst            (rst),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_addr  (core_req_addr),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_instr (core_rsp_instr),
        .core_rsp_addr  (core_rsp_addr),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synthetic instruction memory; the 0xBEE0 line carries recognisable words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h0000BEE) return 32'h1111_1111 * (32'(w[3:2]) + 32'd1);
        return {w[15:0], w[31:16]} ^ 32'h9E37_79B9 ^ (w << 3);
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] base);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = mem_word(base + 32'(4 * i));
        return d;
    endfunction

    function automatic int m_set(input logic [31:0] pc);
        return int'((pc >> 4) % SETS);
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s;
        s = m_set(pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == (pc >> 4)) return w;
        return -1;
    endfunction

    task automatic m_touch(input int s, input int w);
        for (int l = 0; l < LVLS; l++)
            m_node[s][(1 << l) - 1 + (w >> (LVLS - l))] = (((w >> (LVLS - 1 - l)) & 1) == 0);
    endtask

    function automatic int m_victim(input int s);
        int v;
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
        v = 0;
        for (int l = 0; l < LVLS; l++) v = 2 * v + int'(m_node[s][(1 << l) - 1 + v]);
        return v;
    endfunction

    task automatic m_fill(input logic [31:0] pc);
        int s;
        int v;
        s = m_set(pc);
        v = m_victim(s);
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = pc >> 4;
        m_touch(s, v);
    endtask

    task automatic m_flush();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) m_node[s][n] = 1'b0;
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (core_req_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_counters();
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
    endtask

    // One complete fetch from an IDLE negedge back to an IDLE negedge.
    task automatic fetch(input logic [31:0] pc, input int stall, input bit flush_in_wait,
                         output bit was_hit, output logic [31:0] instr);
        int          n;
        int          exp_way;
        logic [31:0] line_a;
        exp_way = m_find(pc);
        line_a  = {pc[31:4], 4'b0000};
        core_req_valid = 1'b1;
        core_req_addr  = pc;
        #1;
        n = 0;
        while (core_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        core_req_valid = 1'b0;
        was_hit = core_rsp_valid;
        instr   = core_rsp_instr;
        check("hit_vs_model", 32'(core_rsp_valid), 32'(exp_way >= 0));
        if (core_rsp_valid === 1'b1) begin
            check("hit_instr", core_rsp_instr, mem_word(pc));
            check("hit_addr", core_rsp_addr, pc);
            m_hits++;
            if (exp_way >= 0) m_touch(m_set(pc), exp_way);
            @(negedge clk);
        end else begin
            m_misses++;
            @(negedge clk);
            mem_req_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                check("stall_req_valid", 32'(mem_req_valid), 32'd1);
                check("stall_req_addr", mem_req_addr, line_a);
                check("stall_core_ready", 32'(core_req_ready), 32'd0);
                @(negedge clk);
            end
            check("mem_req_valid", 32'(mem_req_valid), 32'd1);
            check("mem_req_addr", mem_req_addr, line_a);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("mem_req_dropped", 32'(mem_req_valid), 32'd0);
            check("wait_core_ready", 32'(core_req_ready), 32'd0);
            if (flush_in_wait) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line_data(line_a);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            instr = core_rsp_instr;
            check("fill_rsp_valid", 32'(core_rsp_valid), 32'd1);
            check("fill_instr", core_rsp_instr, mem_word(pc));
            check("fill_addr", core_rsp_addr, pc);
            m_fill(pc);
            @(negedge clk);
            if (flush_in_wait) begin
                count_low(n);
                check("pending_flush_cycles", 32'(n), 32'd4);
                m_flush();
            end
        end
        check_counters();
    endtask

    task automatic flush_idle();
        int n;
        flush          = 1'b1;
        core_req_valid = 1'b1;
        core_req_addr  = 32'h0000_0000;
        #1;
        check("flush_blocks_ready", 32'(core_req_ready), 32'd0);
        @(negedge clk);
        flush          = 1'b0;
        core_req_valid = 1'b0;
        check("flush_no_accept", 32'(core_rsp_valid), 32'd0);
        count_low(n);
        check("idle_flush_cycles", 32'(n), 32'd4);
        m_flush();
    endtask

    initial begin
        bit          h;
        logic [31:0] ins;
        int          hits_before;
        checks         = 0;
        failures       = 0;
        m_hits         = 0;
        m_misses       = 0;
        m_flush();
        rst            = 1'b1;
        core_req_valid = 1'b0;
        core_req_addr  = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;

        repeat (2) @(negedge clk);
        check("rst_core_ready", 32'(core_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(core_rsp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(core_req_ready), 32'd1);
        check_counters();

        // Cold miss then a hit in the same line.
        fetch(32'h0000_BEE8, 0, 1'b0, h, ins);
        check("t1_miss", 32'(h), 32'd0);
        check("t1_instr", ins, 32'h3333_3333);
        check("t1_miss_count", miss_count, 32'd1);
        fetch(32'h0000_BEEC, 0, 1'b0, h, ins);
        check("t1_hit", 32'(h), 32'd1);
        check("t1_hit_instr", ins, 32'h4444_4444);
        check("t1_hit_count", hit_count, 32'd1);

        // PLRU replacement in set 0.
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        fetch(32'h0000_0040, 0, 1'b0, h, ins);
        fetch(32'h0000_0080, 0, 1'b0, h, ins);
        fetch(32'h0000_00C0, 0, 1'b0, h, ins);
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t2_hit_000", 32'(h), 32'd1);
        fetch(32'h0000_0080, 0, 1'b0, h, ins);
        check("t2_hit_080", 32'(h), 32'd1);
        fetch(32'h0000_0100, 0, 1'b0, h, ins);
        check("t2_miss_100", 32'(h), 32'd0);
        fetch(32'h0000_0040, 0, 1'b0, h, ins);
        check("t2_evicted_040", 32'(h), 32'd0);
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t2_kept_000", 32'(h), 32'd1);

        // Back-to-back hits with valid held high.
        hits_before    = m_hits;
        core_req_valid = 1'b1;
        core_req_addr  = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            int w;
            @(negedge clk);
            check("b2b_rsp_valid", 32'(core_rsp_valid), 32'd1);
            check("b2b_ready", 32'(core_req_ready), 32'd1);
            check("b2b_instr", core_rsp_instr, mem_word(32'(4 * i)));
            m_hits++;
            w = m_find(32'(4 * i));
            if (w >= 0) m_touch(0, w);
            if (i < 2) core_req_addr = 32'(4 * (i + 1));
            else       core_req_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_done", 32'(core_rsp_valid), 32'd0);
        check("b2b_hit_delta", hit_count, 32'(hits_before + 3));
        check_counters();

        // Memory backpressure during a miss.
        fetch(32'h0000_0304, 5, 1'b0, h, ins);
        check("t4_miss", 32'(h), 32'd0);

        // Flush in IDLE, then a formerly hitting line misses.
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t5_pre_hit", 32'(h), 32'd1);
        flush_idle();
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t5_post_flush_miss", 32'(h), 32'd0);
        fetch(32'h0000_0418, 1, 1'b1, h, ins);
        check("t5_wait_flush_miss", 32'(h), 32'd0);
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t5_after_pending_flush", 32'(h), 32'd0);

        // Reset while a fill is outstanding.
        core_req_valid = 1'b1;
        core_req_addr  = 32'h0000_0200;
        @(negedge clk);
        core_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("t6_in_wait", 32'(mem_req_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(core_req_ready), 32'd0);
        check("t6_rst_rsp_valid", 32'(core_rsp_valid), 32'd0);
        check("t6_rst_rsp_instr", core_rsp_instr, 32'd0);
        check("t6_rst_rsp_addr", core_rsp_addr, 32'd0);
        check("t6_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("t6_rst_mem_addr", mem_req_addr, 32'd0);
        check("t6_rst_hits", hit_count, 32'd0);
        check("t6_rst_misses", miss_count, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        m_flush();
        #1;
        check("t6_ready_after_rst", 32'(core_req_ready), 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_data(32'h0000_0200);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("t6_stray_rsp", 32'(core_rsp_valid), 32'd0);
        @(negedge clk);
        check("t6_stray_rsp_late", 32'(core_rsp_valid), 32'd0);
        fetch(32'h0000_0000, 0, 1'b0, h, ins);
        check("t6_cold_again", 32'(h), 32'd0);

        // Random fetches over a small address pool, with occasional flushes.
        for (int k = 0; k < 250; k++) begin
            logic [31:0] pc;
            pc = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) flush_idle();
            fetch(pc, $urandom_range(0, 3), ($urandom_range(0, 15) == 0), h, ins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_cache_sa.md
Name: i_cache_sa

Overview:
Parametrised set-associative instruction cache. It replaces the fixed 16-way fully-associative i-cache and sits between the IFU fetch stage and instruction memory. It adds configurable sets, ways and line size, tree-PLRU replacement per set, and valid/ready handshakes on both sides. It also provides a sequential whole-cache flush and hit/miss counters.

Parameters:
SETS, 4, number of sets; power of 2, ≥1
WAYS, 4, ways per set; power of 2, ≥2
LINE_WORDS, 4, 32-bit instructions per line; power of 2, ≥2
Derived: OFF_W = log2(LINE_WORDS*4); IDX_W = log2(SETS); TAG_W = 32-OFF_W-IDX_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
core_req_valid  in  1  fetch request
core_req_ready  out  1  request accepted when valid&ready
core_req_addr  in  32  fetch PC; bits [1:0] ignored
core_rsp_valid  out  1  one-cycle pulse; core always accepts
core_rsp_instr  out  32  fetched instruction
core_rsp_addr  out  32  PC of returned instruction
flush  in  1  one-cycle pulse: invalidate whole cache
mem_req_valid  out  1  line fill request
mem_req_ready  in  1  imem accepts request
mem_req_addr  out  32  line-aligned address (low OFF_W bits zero)
mem_rsp_valid  in  1  fill data valid
mem_rsp_data  in  32*LINE_WORDS  line; word i at bits [32i+31:32i]
hit_count  out  32  wrapping count of hits
miss_count  out  32  wrapping count of misses

Behaviour:
- Address split: tag=[31:OFF_W+IDX_W], index=[OFF_W+IDX_W-1:OFF_W], word=[OFF_W-1:2].
- Storage: tag, data, valid and PLRU (WAYS-1 bits per set) held in flops.
- Reset: state IDLE. All valid and PLRU bits 0. Counters 0. All outputs 0, except core_req_ready=1 once rst is low. A fill in flight is abandoned.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESPOND, FLUSH.
- IDLE: core_req_ready=1. On accept, latch the address -> LOOKUP.
- LOOKUP: compare against all ways of the set.
  - Hit: core_rsp_valid=1 this cycle (1 cycle after accept); hit_count++; update PLRU.
  - core_req_ready=1 on a hit, so back-to-back hits give one response per cycle. With no new request -> IDLE.
  - Miss: miss_count++ -> MISS_REQ.
- MISS_REQ: mem_req_valid=1; mem_req_addr holds stable until mem_req_ready. On handshake -> MISS_WAIT.
- MISS_WAIT: on mem_rsp_valid, write the victim way: tag, data, valid=1; update PLRU -> RESPOND.
- Victim selection: the lowest-index invalid way in the set, otherwise the PLRU victim.
- RESPOND: core_rsp_valid=1 with the selected word of the filled line -> IDLE (or FLUSH if a flush is pending).
- core_req_ready=0 in MISS_REQ, MISS_WAIT, RESPOND and FLUSH.
- Tree-PLRU: node bit 0 means the victim is in the lower half, 1 the upper half.
  - On an access to way w, every node on w's path is set to point away from w.
  - The victim is found by following the bits from the root.
- FLUSH: clears valid and PLRU for one set per cycle, sets 0..SETS-1 (SETS cycles), then -> IDLE. Counters are unaffected.
- Flush in IDLE, or in LOOKUP on a hit: enters FLUSH next cycle. Any core request in that cycle is not accepted.
- Flush during MISS_REQ, MISS_WAIT or a LOOKUP miss: latched as pending. The fill and response complete first, then FLUSH runs.
- A second flush during FLUSH is absorbed.
- mem_rsp_valid outside MISS_WAIT is ignored.
- A fill is written even if its address aliases a line already present; no duplicate tags are possible because a miss implies absence.

Test Plan:
1. Cold miss: req 0x0000_BEE8 -> mem_req_addr 0x0000_BEE0.
   Return data word0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> core_rsp_instr 0x33333333, core_rsp_addr 0x0000_BEE8, miss_count=1.
   Then req 0x0000_BEEC -> rsp 1 cycle after accept, 0x44444444, hit_count=1.
2. PLRU: fill 0x000, 0x040, 0x080, 0x0C0 (set 0) into ways 0..3; hit 0x000 then 0x080.
   Miss 0x100 -> replaces way 1 (0x040). Afterwards 0x040 misses and 0x000 hits.
3. Back-to-back hits: valid held high on 0x000, 0x004, 0x008 -> core_req_ready stays 1; three responses on consecutive cycles, hit_count +3.
4. Backpressure: mem_req_ready low for 5 cycles during a miss -> mem_req_valid and mem_req_addr stable, core_req_ready=0.
   Response arrives 1 cycle after the fill.
5. Flush: pulse in IDLE -> core_req_ready=0 for exactly 4 cycles; a previously hitting 0x000 then misses.
   Flush pulsed in MISS_WAIT -> the fill response is delivered first, then 4 flush cycles.
6. Reset asserted in MISS_WAIT -> all outputs 0 immediately.
   A stray mem_rsp_valid after release produces no core_rsp_valid; 0x000 misses.
